// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates tags at tail, captures CDB results out of order,
// and retires the head entry through a registered commit write port.
module rob_commit_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int RF_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  alloc_valid,
    input  logic                  alloc_has_rd,
    input  logic [RF_WIDTH-1:0]   alloc_rd,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  destinationTag,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  commit_valid,
    output logic                  commit_has_rd,
    output logic [RF_WIDTH-1:0]   commit_rd,
    output logic [TAG_WIDTH-1:0]  commit_tag,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic                  rob_empty
);

    localparam int DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);
    localparam logic [TAG_WIDTH:0]   COUNT_ONE  = (TAG_WIDTH + 1)'(1);
    localparam logic [TAG_WIDTH-1:0] TAG_ONE    = TAG_WIDTH'(1);

    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      done_q;
    logic [DEPTH-1:0]      has_rd_q;
    logic [RF_WIDTH-1:0]   rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [TAG_WIDTH-1:0]  head_q;
    logic [TAG_WIDTH-1:0]  tail_q;
    logic [TAG_WIDTH:0]    count_q;

    logic alloc_fire;
    logic commit_fire;
    logic cdb_fire;

    // Commit looks only at stored done bits, so a same-cycle CDB result waits one edge.
    always_comb begin
        alloc_ready    = (count_q != FULL_COUNT) && !halt;
        destinationTag = tail_q;
        rob_empty      = (count_q == '0);
        alloc_fire     = alloc_valid && alloc_ready;
        commit_fire    = !halt && (count_q != '0) && done_q[head_q];
        cdb_fire       = cdb_valid && busy_q[cdb_tag] && !done_q[cdb_tag];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_valid  <= 1'b0;
            commit_has_rd <= 1'b0;
            commit_rd     <= '0;
            commit_tag    <= '0;
            commit_data   <= '0;
        end else begin
            if (cdb_fire) begin
                done_q[cdb_tag] <= 1'b1;
            end
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                tail_q         <= tail_q + TAG_ONE;
            end
            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + TAG_ONE;
                commit_valid   <= 1'b1;
                commit_has_rd  <= has_rd_q[head_q];
                commit_rd      <= rd_q[head_q];
                commit_tag     <= head_q;
                commit_data    <= data_q[head_q];
            end else begin
                commit_valid <= 1'b0;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; busy/done gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail_q]     <= alloc_rd;
            has_rd_q[tail_q] <= alloc_has_rd && (alloc_rd != '0);
        end
        if (cdb_fire) begin
            data_q[cdb_tag] <= cdb_data;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: directed stimulus queues expected commits,
// a negedge monitor pops and compares each presented commit.
module tb_rob_commit_unit;

    localparam int DW = 32;
    localparam int TW = 7;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          alloc_valid;
    logic          alloc_has_rd;
    logic [RW-1:0] alloc_rd;
    logic          alloc_ready;
    logic [TW-1:0] destinationTag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          commit_valid;
    logic          commit_has_rd;
    logic [RW-1:0] commit_rd;
    logic [TW-1:0] commit_tag;
    logic [DW-1:0] commit_data;
    logic          rob_empty;

    always #5 clk = ~clk;

    rob_commit_unit #(
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW),
        .RF_WIDTH  (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .alloc_valid   (alloc_valid),
        .alloc_has_rd  (alloc_has_rd),
        .alloc_rd      (alloc_rd),
        .alloc_ready   (alloc_ready),
        .destinationTag(destinationTag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .commit_valid  (commit_valid),
        .commit_has_rd (commit_has_rd),
        .commit_rd     (commit_rd),
        .commit_tag    (commit_tag),
        .commit_data   (commit_data),
        .rob_empty     (rob_empty)
    );

    typedef struct packed {
        logic [RW-1:0] rd;
        logic          has_rd;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int rd, input bit has, input int tag, input logic [DW-1:0] data);
        exp_t e;
        e.rd     = RW'(rd);
        e.has_rd = has;
        e.tag    = TW'(tag);
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic cdb(input int tag, input logic [DW-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = TW'(tag);
        cdb_data  = data;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, DW'(sb.size()), '0);
    endtask

    initial begin
        rst          = 1'b1;
        halt         = 1'b0;
        alloc_valid  = 1'b0;
        alloc_has_rd = 1'b0;
        alloc_rd     = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;

        fork
            forever begin
                exp_t act;
                exp_t e;
                @(negedge clk);
                if (commit_valid) begin
                    act = {commit_rd, commit_has_rd, commit_tag, commit_data};
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL commit_unexpected: got rd=%0d has=%0d tag=%0d data=0x%0h expected no commit",
                                 commit_rd, commit_has_rd, commit_tag, commit_data);
                    end else begin
                        e = sb.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL commit_entry: got rd=%0d has=%0d tag=%0d data=0x%0h expected rd=%0d has=%0d tag=%0d data=0x%0h",
                                     commit_rd, commit_has_rd, commit_tag, commit_data, e.rd, e.has_rd, e.tag, e.data);
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL timeout: got no end of run expected finish");
                $fatal(1);
            end
        join_none

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("reset_alloc_ready", DW'(alloc_ready), 1);
        chk("reset_dest_tag", DW'(destinationTag), 0);
        chk("reset_rob_empty", DW'(rob_empty), 1);
        chk("reset_commit_valid", DW'(commit_valid), 0);
        chk("reset_commit_data", commit_data, 0);

        // Out-of-order completion, in-order retire
        alloc_valid = 1'b1; alloc_has_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = RW'(3 + i);
            #1;
            chk("alloc_dest_tag", DW'(destinationTag), DW'(i));
            tick();
        end
        alloc_valid = 1'b0;
        push(3, 1, 0, 32'hA);
        push(4, 1, 1, 32'hB);
        push(5, 1, 2, 32'hC);
        cdb(2, 32'hC); tick();
        cdb(0, 32'hA); tick();
        chk("latency_not_early", DW'(commit_valid), 0);
        cdb(1, 32'hB); tick();
        cdb_valid = 1'b0;
        chk("latency_commit_valid", DW'(commit_valid), 1);
        chk("latency_commit_tag", DW'(commit_tag), 0);
        drain("drain_ooo");
        chk("ooo_rob_empty", DW'(rob_empty), 1);

        // Fill to capacity, reject 129th, wrap after one retire
        rst = 1'b1; tick(); rst = 1'b0;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1;
        for (int i = 0; i < 128; i++) begin
            alloc_rd = RW'(i % 31 + 1);
            tick();
        end
        chk("full_alloc_ready", DW'(alloc_ready), 0);
        chk("full_rob_empty", DW'(rob_empty), 0);
        chk("full_dest_tag", DW'(destinationTag), 0);
        tick();
        chk("full_reject_tag", DW'(destinationTag), 0);
        chk("full_reject_ready", DW'(alloc_ready), 0);
        push(1, 1, 0, 32'h55);
        cdb(0, 32'h55); tick();
        cdb_valid = 1'b0;
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("wrap_alloc_ready", DW'(alloc_ready), 1);
        chk("wrap_dest_tag", DW'(destinationTag), 0);
        drain("drain_full");

        // x0 destination never writes the RF
        rst = 1'b1; tick(); rst = 1'b0;
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_rd = '0;
        tick();
        alloc_valid = 1'b0;
        push(0, 0, 0, 32'h77);
        cdb(0, 32'h77); tick();
        cdb_valid = 1'b0;
        drain("drain_x0");

        // CDB to free tag ignored; repeat CDB to done entry ignored
        alloc_valid = 1'b1; alloc_has_rd = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            alloc_rd = RW'(t);
            if (t == 1) cdb(9, 32'hFF);
            else cdb_valid = 1'b0;
            tick();
        end
        alloc_valid = 1'b0;
        for (int t = 1; t <= 8; t++) push(t, 1, t, 32'h100 + t);
        push(9, 1, 9, 32'h11);
        cdb(9, 32'h11); tick();
        cdb(9, 32'h22); tick();
        for (int t = 1; t <= 8; t++) begin
            cdb(t, 32'h100 + t);
            tick();
        end
        cdb_valid = 1'b0;
        drain("drain_tag9");

        // Halt freezes commit/alloc but not capture
        alloc_valid = 1'b1; alloc_has_rd = 1'b1;
        alloc_rd = 5'd7; tick();
        alloc_rd = 5'd8; tick();
        alloc_valid = 1'b0;
        push(7, 1, 10, 32'h33);
        push(8, 1, 11, 32'h44);
        cdb(10, 32'h33); tick();
        cdb(11, 32'h44); halt = 1'b1;
        #1;
        chk("halt_alloc_ready", DW'(alloc_ready), 0);
        tick();
        chk("halt_no_commit_1", DW'(commit_valid), 0);
        cdb_valid = 1'b0;
        tick();
        chk("halt_no_commit_2", DW'(commit_valid), 0);
        halt = 1'b0;
        tick();
        chk("unhalt_commit_valid", DW'(commit_valid), 1);
        chk("unhalt_commit_tag", DW'(commit_tag), 10);
        tick();
        chk("halt_capture_data", commit_data, 32'h44);
        drain("drain_halt");

        // Reset mid-stream with 5 live entries
        alloc_valid = 1'b1; alloc_has_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_rd = RW'(9 + i);
            tick();
        end
        rst = 1'b1; alloc_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_rob_empty", DW'(rob_empty), 1);
        chk("midrst_commit_valid", DW'(commit_valid), 0);
        chk("midrst_dest_tag", DW'(destinationTag), 0);
        chk("midrst_alloc_ready", DW'(alloc_ready), 1);
        cdb(12, 32'h99); tick();
        cdb_valid = 1'b0;
        tick(); tick();
        chk("midrst_stale_commit", DW'(commit_valid), 0);
        chk("midrst_still_empty", DW'(rob_empty), 1);
        chk("final_sb_empty", DW'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
